// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulo counter family.
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP  = 1'b1} count_dir_e;
  typedef enum logic {LIM_WRAP = 1'b0, LIM_SAT = 1'b1} limit_mode_e;

  function automatic int unsigned clamp_to_max(input int unsigned val,
                                               input int unsigned max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-qualifier divider, present only when COUNTER_PRESCALE_EN is defined.
// It emits tick on the enabled cycle where the divider sits at PRESCALE-1.
`ifdef COUNTER_PRESCALE_EN
module counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DW = $clog2(PRESCALE);
  localparam logic [DW-1:0] LAST = DW'(PRESCALE - 1);

  logic [DW-1:0] r_div;

  assign tick = en && (r_div == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (clr) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= tick ? '0 : r_div + DW'(1);
    end
  end

endmodule
`endif

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap/saturate mode and registered wrap pulse.
// Define COUNTER_PRESCALE_EN to step only every PRESCALE enabled cycles.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_MAX  = (2 ** WIDTH) - 1,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD_MAX);

  if (WIDTH < 2 || MOD_MAX < 1 || PRESCALE < 2) begin : g_param_err
    $error("updown_mod_counter: illegal parameter combination");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next_count;
  logic             w_next_wrap;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_tick;
  logic             w_at_limit;
  count_dir_e       w_dir;
  limit_mode_e      w_mode;

  assign w_dir  = up  ? DIR_UP  : DIR_DOWN;
  assign w_mode = sat ? LIM_SAT : LIM_WRAP;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  assign w_at_limit     = (w_dir == DIR_UP) ? (r_count == MAX_C) : (r_count == '0);
  assign w_load_clamped = WIDTH'(clamp_to_max(32'(load_val), MOD_MAX));

  // Explicit limit compare, so a full-range MOD_MAX behaves like binary wrap.
  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    if (load) begin
      w_next_count = w_load_clamped;
    end else if (en && w_tick) begin
      if (w_at_limit) begin
        if (w_mode == LIM_WRAP) begin
          w_next_count = (w_dir == DIR_UP) ? '0 : MAX_C;
          w_next_wrap  = 1'b1;
        end
      end else if (w_dir == DIR_UP) begin
        w_next_count = r_count + WIDTH'(1);
      end else begin
        w_next_count = r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign at_limit = w_at_limit;

endmodule
